ro_bus_scheduler: RTL and testbench
===================================

Name: ro_bus_scheduler

Overview:
- Time-multiplexes N_CH readout blocks onto one shared 2-bit tristate output bus.
- Generates one-hot tristate-enable lines (ro_ctrl), one per readout block, replacing per-block free-running enables.
- One frame is started by each falling edge of the div-32 clock. Inside the frame, each channel enabled in the mask is granted a fixed drive slot.
- A guard gap is inserted between slots so that two blocks never drive the bus in the same cycle.

Parameters:
- N_CH, 8, number of readout blocks sharing the bus.
- SLOT_CYC, 3, clk_ext cycles each granted channel drives the bus (≥1).
- GUARD_CYC, 1, all-off clk_ext cycles before every slot (≥1).

Ports:
- clk_ext, input, 1, system clock. All logic is on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- clk_32, input, 1, div-32 clock derived from clk_ext. It is sampled as data, not used as a clock.
- ch_mask, input, N_CH, per-channel participation. Latched at frame start.
- clr_ovr, input, 1, clears the sticky overrun flag.
- ro_ctrl, output, N_CH, one-hot-or-zero enables. Bit i=1 means block i drives the bus.
- slot_idx, output, $clog2(N_CH), index of the channel currently driving. 0 when none is driving.
- frame_start, output, 1, one-cycle pulse marking the start of a frame.
- frame_done, output, 1, one-cycle pulse on return to IDLE after a completed frame.
- busy, output, 1, high whenever state ≠ IDLE.
- overrun, output, 1, sticky. Set when a new frame edge arrives while busy.

Behaviour:
- Reset:
  - Applies while rst=1 at a clk_ext edge.
  - Outputs: ro_ctrl=0, slot_idx=0, frame_start=0, frame_done=0, busy=0, overrun=0.
  - Internal: state=IDLE, c32_q=0, mask register=0.
  - Reset mid-slot drops ro_ctrl to 0 on the same edge.
- Edge detect:
  - c32_q is the registered copy of clk_32.
  - fall = c32_q & ~clk_32, a combinational decode in cycle t.
- Frame start: when fall=1 in cycle t:
  - mask_r<=ch_mask and state<=GUARD.
  - frame_start=1 in cycle t+1 only.
  - guard counter loaded so that GUARD lasts GUARD_CYC cycles.
- States: IDLE, GUARD, DRIVE. All outputs are registered.
- GUARD:
  - ro_ctrl=0 throughout.
  - After GUARD_CYC cycles, search mask_r for the lowest set bit at index ≥ next pointer (pointer=0 at frame start).
  - Bit found: state=DRIVE, slot_idx=that index, ro_ctrl=1<<index for SLOT_CYC cycles.
  - No bit found: state=IDLE, frame_done=1 for one cycle.
- DRIVE:
  - After SLOT_CYC cycles: pointer=slot_idx+1, ro_ctrl=0, state=GUARD.
  - When pointer reaches N_CH, the next GUARD completes to IDLE.
- Frame length = GUARD_CYC + k·(SLOT_CYC+GUARD_CYC) cycles, where k = popcount(mask_r).
- With defaults and a full mask: 8·4+1 = 33 cycles. This exceeds the 32-cycle period, so overrun is expected; software limits the mask to ≤7 channels or sets SLOT_CYC=2.
- Mask zero: frame_start, then GUARD_CYC cycles, then frame_done. No enable is ever raised.
- ch_mask changes mid-frame are ignored until the next frame start.
- Overrun: fall=1 while busy=1 causes all of the following on the same edge:
  - overrun<=1.
  - Current frame aborted: ro_ctrl<=0, pointer reset.
  - New frame started: mask relatched, state=GUARD, frame_start pulse.
  - No frame_done pulse for the aborted frame.
- Simultaneous fall and natural frame completion in the same cycle: treated as overrun (busy is still 1).
- clr_ovr=1 clears overrun. If a set condition occurs in the same cycle, set wins.
- Invariants:
  - popcount(ro_ctrl) ≤ 1 in every cycle.
  - Between any two different nonzero ro_ctrl values there are ≥GUARD_CYC zero cycles.

Test Plan:
1. Reset with clk_32 toggling and rst=1 for 5 cycles → all outputs 0 and no frame_start. After release, the first clk_32 fall gives frame_start exactly one cycle after the cycle in which fall was detected.
2. ch_mask=8'b0000_0101, defaults → ro_ctrl sequence: 1 cycle 0, 3 cycles 8'h01 (slot_idx=0), 1 cycle 0, 3 cycles 8'h04 (slot_idx=2), 1 cycle 0. frame_done on cycle 9 after frame_start. Frame length 9.
3. ch_mask=0 → frame_start, one guard cycle, then frame_done. ro_ctrl stays 0. busy is high for exactly 1 cycle.
4. ch_mask=8'hFF, defaults → 33-cycle frame collides with the next fall. overrun=1, ro_ctrl=0 on that edge, and a new frame restarts at channel 0. Then pulse clr_ovr → overrun=0.
5. Change ch_mask from 8'h01 to 8'h80 in the middle of a frame → the current frame still grants only channel 0. The next frame grants only channel 7 (ro_ctrl=8'h80, slot_idx=7).
6. Assert rst during DRIVE of channel 3 → ro_ctrl=0 on that edge. The next frame after release restarts from channel 0. An assertion checks popcount(ro_ctrl) ≤ 1 throughout all tests.

Source files
------------

// File: rtl/ro_bus_scheduler.sv
// -----------------------------------------------------------------------------
// ro_bus_scheduler
//
// Time-multiplexes N_CH readout blocks onto one shared tristate output bus.
// Each falling edge of the div-32 clock starts a frame. Inside a frame, every
// channel enabled in the latched mask is granted one SLOT_CYC-long drive slot,
// in ascending channel order. Every slot is preceded by GUARD_CYC all-off
// cycles, so two blocks never drive the bus in the same cycle.
//
// Ports:
//   clk_ext     in   system clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   clk_32      in   div-32 clock, sampled as data (never used as a clock)
//   ch_mask     in   per-channel participation, latched at frame start
//   clr_ovr     in   clears the sticky overrun flag (a same-cycle set wins)
//   ro_ctrl     out  one-hot-or-zero tristate enables, bit i = block i drives
//   slot_idx    out  index of the driving channel, 0 when none drives
//   frame_start out  one-cycle pulse at the start of a frame
//   frame_done  out  one-cycle pulse on return to idle after a full frame
//   busy        out  high whenever the scheduler is not idle
//   overrun     out  sticky, set when a frame edge arrives while busy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ro_bus_scheduler #(
    parameter int N_CH      = 8,
    parameter int SLOT_CYC  = 3,
    parameter int GUARD_CYC = 1
) (
    input  logic                    clk_ext,
    input  logic                    rst,
    input  logic                    clk_32,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic                    clr_ovr,
    output logic [N_CH-1:0]         ro_ctrl,
    output logic [$clog2(N_CH)-1:0] slot_idx,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W   = $clog2(N_CH);
    // The pointer has to be able to hold N_CH itself ("past the last channel").
    localparam int PTR_W   = $clog2(N_CH + 1);
    localparam int CNT_MAX = (SLOT_CYC > GUARD_CYC) ? SLOT_CYC : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counters run down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LOAD  = CNT_W'(SLOT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } state_e;

    state_e            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [PTR_W-1:0]  ptr_q,         ptr_d;
    logic [N_CH-1:0]   mask_q,        mask_d;
    logic              c32_q,         c32_d;
    logic [N_CH-1:0]   ro_ctrl_q,     ro_ctrl_d;
    logic [IDX_W-1:0]  slot_idx_q,    slot_idx_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q,  frame_done_d;
    logic              busy_q,        busy_d;
    logic              overrun_q,     overrun_d;

    logic              fall;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;

    // Falling edge of clk_32, decoded against last cycle's sample.
    assign fall  = c32_q & ~clk_32;
    assign c32_d = clk_32;

    // Lowest set bit of the latched mask at or above the pointer. Scanning
    // downward lets the lowest match overwrite any higher one.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        mask_d        = mask_q;
        ro_ctrl_d     = ro_ctrl_q;
        slot_idx_d    = slot_idx_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        overrun_d     = overrun_q;

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    if (hit) begin
                        state_d            = ST_DRIVE;
                        cnt_d              = SLOT_LOAD;
                        slot_idx_d         = hit_idx;
                        ro_ctrl_d          = '0;
                        ro_ctrl_d[hit_idx] = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        ptr_d        = '0;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d    = ST_GUARD;
                    cnt_d      = GUARD_LOAD;
                    ptr_d      = PTR_W'(slot_idx_q) + PTR_W'(1);
                    ro_ctrl_d  = '0;
                    slot_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                // Idle: wait for the next frame edge.
            end
        endcase

        // A frame edge overrides whatever the frame was doing, including a
        // completion in this same cycle: the old frame is dropped silently
        // (no frame_done) and a fresh one starts from channel 0.
        if (fall) begin
            state_d       = ST_GUARD;
            cnt_d         = GUARD_LOAD;
            ptr_d         = '0;
            mask_d        = ch_mask;
            ro_ctrl_d     = '0;
            slot_idx_d    = '0;
            frame_start_d = 1'b1;
            frame_done_d  = 1'b0;
        end

        // Clear first, so a set in the same cycle wins.
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (fall && busy_q) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            mask_q        <= '0;
            c32_q         <= 1'b0;
            ro_ctrl_q     <= '0;
            slot_idx_q    <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            mask_q        <= mask_d;
            c32_q         <= c32_d;
            ro_ctrl_q     <= ro_ctrl_d;
            slot_idx_q    <= slot_idx_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign ro_ctrl     = ro_ctrl_q;
    assign slot_idx    = slot_idx_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ro_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ro_bus_scheduler
//
// Directed bench for ro_bus_scheduler with default parameters. Inputs change
// and outputs are sampled on the falling edge of clk_ext. The bench generates
// clk_32 itself (16 cycles high, 16 low), so it knows the cycle t in which
// each clk_32 fall is presented; expected values are written relative to t.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ro_bus_scheduler;

    localparam int N_CH = 8;

    logic            clk_ext = 1'b0;
    logic            rst;
    logic            clk_32;
    logic [N_CH-1:0] ch_mask;
    logic            clr_ovr;
    logic [N_CH-1:0] ro_ctrl;
    logic [2:0]      slot_idx;
    logic            frame_start;
    logic            frame_done;
    logic            busy;
    logic            overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    int   phase;
    logic fell;

    // Hand-derived 0x05 frame, index k = cycles after the fall cycle.
    logic [7:0] exp2_ro   [1:10] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00,
                                     8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    int         exp2_slot [1:10] = '{0, 0, 0, 0, 0, 2, 2, 2, 0, 0};
    logic [10:1] exp2_busy = 10'b0111111111;
    logic [10:1] exp2_fs   = 10'b0000000001;
    logic [10:1] exp2_fd   = 10'b1000000000;

    ro_bus_scheduler dut (
        .clk_ext     (clk_ext),
        .rst         (rst),
        .clk_32      (clk_32),
        .ch_mask     (ch_mask),
        .clr_ovr     (clr_ovr),
        .ro_ctrl     (ro_ctrl),
        .slot_idx    (slot_idx),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Advance to the next sampling point and present this cycle's clk_32.
    task automatic next_cycle();
        logic nv;
        @(negedge clk_ext);
        nv     = (phase < 16);
        fell   = clk_32 & ~nv;
        clk_32 = nv;
        phase  = (phase + 1) % 32;
    endtask

    // Returns in the cycle t in which a clk_32 fall is presented.
    task automatic wait_fall();
        int n = 0;
        do begin
            next_cycle();
            n++;
        end while (!fell && n < 40);
        if (!fell) begin
            $display("FAIL wait_fall: no clk_32 fall within %0d cycles", n);
            $fatal(1, "stimulus stalled");
        end
    endtask

    // At most one block may drive the bus in any cycle.
    always @(negedge clk_ext) begin
        chk("onehot", 32'($countones(ro_ctrl) <= 1), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        clk_32  = 1'b1;
        clr_ovr = 1'b0;
        ch_mask = 8'h00;
        phase   = 15;
        fell    = 1'b0;

        // Reset held for 5 cycles while clk_32 falls underneath it.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            chk($sformatf("reset outputs c%0d", i),
                32'({ro_ctrl, slot_idx, frame_start, frame_done, busy, overrun}), 32'd0);
        end
        rst = 1'b0;

        // First fall after release, with an all-zero mask.
        wait_fall();
        chk("t1 frame_start at t", 32'(frame_start), 32'd0);
        next_cycle();
        chk("t1 frame_start t+1", 32'(frame_start), 32'd1);
        chk("t3 busy t+1",        32'(busy),        32'd1);
        chk("t3 ro_ctrl t+1",     32'(ro_ctrl),     32'd0);
        next_cycle();
        chk("t1 frame_start t+2", 32'(frame_start), 32'd0);
        chk("t3 busy t+2",        32'(busy),        32'd0);
        chk("t3 frame_done t+2",  32'(frame_done),  32'd1);
        chk("t3 ro_ctrl t+2",     32'(ro_ctrl),     32'd0);
        next_cycle();
        chk("t3 frame_done t+3",  32'(frame_done),  32'd0);

        // Two-channel frame.
        ch_mask = 8'h05;
        wait_fall();
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            chk($sformatf("t2 ro_ctrl k%0d", k),     32'(ro_ctrl),     32'(exp2_ro[k]));
            chk($sformatf("t2 slot_idx k%0d", k),    32'(slot_idx),    32'(exp2_slot[k]));
            chk($sformatf("t2 frame_start k%0d", k), 32'(frame_start), 32'(exp2_fs[k]));
            chk($sformatf("t2 frame_done k%0d", k),  32'(frame_done),  32'(exp2_fd[k]));
            chk($sformatf("t2 busy k%0d", k),        32'(busy),        32'(exp2_busy[k]));
            chk($sformatf("t2 overrun k%0d", k),     32'(overrun),     32'd0);
        end

        // Mask change mid-frame only takes effect at the next frame.
        ch_mask = 8'h01;
        wait_fall();
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            chk($sformatf("t5a ro_ctrl k%0d", k), 32'(ro_ctrl),
                (k >= 2 && k <= 4) ? 32'h01 : 32'h00);
            chk($sformatf("t5a frame_done k%0d", k), 32'(frame_done), (k == 6) ? 32'd1 : 32'd0);
            if (k == 3) ch_mask = 8'h80;
        end
        wait_fall();
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            chk($sformatf("t5b ro_ctrl k%0d", k), 32'(ro_ctrl),
                (k >= 2 && k <= 4) ? 32'h80 : 32'h00);
            chk($sformatf("t5b slot_idx k%0d", k), 32'(slot_idx),
                (k >= 2 && k <= 4) ? 32'd7 : 32'd0);
            chk($sformatf("t5b frame_done k%0d", k), 32'(frame_done), (k == 6) ? 32'd1 : 32'd0);
        end

        // Full mask: the 33-cycle frame is cut by the fall 32 cycles later.
        ch_mask = 8'hFF;
        wait_fall();
        for (int k = 1; k <= 35; k++) begin
            next_cycle();
            if (k == 1) chk("t4 frame_start k1", 32'(frame_start), 32'd1);
            if (k == 2) begin
                chk("t4 ro_ctrl k2",  32'(ro_ctrl),  32'h01);
                chk("t4 slot_idx k2", 32'(slot_idx), 32'd0);
            end
            if (k == 31) begin
                chk("t4 ro_ctrl k31",  32'(ro_ctrl),  32'h80);
                chk("t4 slot_idx k31", 32'(slot_idx), 32'd7);
            end
            if (k == 32) begin
                chk("t4 ro_ctrl k32", 32'(ro_ctrl), 32'h80);
                chk("t4 overrun k32", 32'(overrun), 32'd0);
                chk("t4 busy k32",    32'(busy),    32'd1);
            end
            if (k == 33) begin
                chk("t4 ro_ctrl k33",     32'(ro_ctrl),     32'h00);
                chk("t4 slot_idx k33",    32'(slot_idx),    32'd0);
                chk("t4 overrun k33",     32'(overrun),     32'd1);
                chk("t4 frame_start k33", 32'(frame_start), 32'd1);
                chk("t4 frame_done k33",  32'(frame_done),  32'd0);
                chk("t4 busy k33",        32'(busy),        32'd1);
            end
            if (k == 34) begin
                chk("t4 ro_ctrl k34",  32'(ro_ctrl),  32'h01);
                chk("t4 slot_idx k34", 32'(slot_idx), 32'd0);
                chk("t4 overrun k34",  32'(overrun),  32'd1);
                clr_ovr = 1'b1;
            end
            if (k == 35) begin
                chk("t4 overrun k35", 32'(overrun), 32'd0);
                chk("t4 ro_ctrl k35", 32'(ro_ctrl), 32'h01);
                clr_ovr = 1'b0;
            end
        end

        // Reset during channel 3's slot. The full-mask frame is still running
        // when this fall arrives, so overrun is set again first.
        ch_mask = 8'h0F;
        wait_fall();
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            if (k == 1) chk("t6 overrun k1", 32'(overrun), 32'd1);
            if (k == 14) begin
                chk("t6 ro_ctrl k14",  32'(ro_ctrl),  32'h08);
                chk("t6 slot_idx k14", 32'(slot_idx), 32'd3);
                rst = 1'b1;
            end
            if (k == 15) begin
                chk("t6 ro_ctrl k15",  32'(ro_ctrl),  32'h00);
                chk("t6 slot_idx k15", 32'(slot_idx), 32'd0);
                chk("t6 busy k15",     32'(busy),     32'd0);
                chk("t6 overrun k15",  32'(overrun),  32'd0);
                rst = 1'b0;
            end
        end
        wait_fall();
        next_cycle();
        chk("t6 frame_start restart", 32'(frame_start), 32'd1);
        next_cycle();
        chk("t6 ro_ctrl restart",  32'(ro_ctrl),  32'h01);
        chk("t6 slot_idx restart", 32'(slot_idx), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
